// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   UART 8N1 receiver. The asynchronous uart_rx line passes through a 2-FF
//   synchroniser. A falling edge on the synchronised line starts a frame.
//   Each bit is sampled three times around mid-bit, and a majority vote
//   decides the bit value. A start bit that is high at mid-bit is treated as
//   a false start and ignored. A low stop bit is reported as a framing error.
//   Each good byte is delivered with a single-cycle rx_valid pulse.
//
// Ports
//   sys_clk       in   1  system clock (sole clock)
//   rst_n         in   1  asynchronous, active-low reset
//   uart_rx       in   1  serial input, idle high, asynchronous to sys_clk
//   rx_data       out  8  last correctly framed byte, held until next good byte
//   rx_valid      out  1  one-cycle pulse: rx_data just updated
//   rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
//   rx_busy       out  1  high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST   = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_SAMP_A = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_SAMP_B = CW'(HALF);
  localparam logic [CW-1:0] CNT_DECIDE = CW'(HALF + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_s, rx_s_d;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            samp_a, samp_b;
  logic            fall_edge, decide, majority;
  logic            valid_next, err_next, load_data, shift_en;

  // The synchroniser flops reset to the idle (high) level. Otherwise the
  // release of reset could look like a start edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall_edge = rx_s_d & ~rx_s;
  assign decide    = (baud_cnt == CNT_DECIDE);

  // The third vote is the live synchronised sample taken in the decision cycle.
  assign majority  = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  assign rx_busy   = (state != IDLE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    err_next   = 1'b0;
    load_data  = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        // Only a genuine high->low transition starts a frame. A line held
        // low (break) therefore never retriggers.
        if (fall_edge) begin
          state_next = START;
        end
      end
      START: begin
        if (decide) begin
          state_next = majority ? IDLE : DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        // Return to IDLE mid stop bit, so that the next start edge is
        // caught even when frames are sent back to back.
        if (decide) begin
          state_next = IDLE;
          if (majority) begin
            valid_next = 1'b1;
            load_data  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The baud counter is held at zero while idle. This also gives the
  // required clear on entry to START.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (state != IDLE) begin
      if (baud_cnt == CNT_SAMP_A) samp_a <= rx_s;
      if (baud_cnt == CNT_SAMP_B) samp_b <= rx_s;
    end
  end

  // Data arrives LSB first, so each new bit enters at the MSB and shifts down.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (state == START) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) begin
        shift_reg <= {majority, shift_reg[7:1]};
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= valid_next;
      rx_frame_err <= err_next;
      if (load_data) begin
        rx_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
//   Directed testbench for uart_rx_byte at 50 MHz / 115200 baud
//   (434 clocks per bit). Serial frames are driven on the pin. A monitor
//   collects the received bytes and pulse statistics, and the results are
//   compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte;

  localparam int BIT_P  = 434;
  localparam int HALF   = 217;
  localparam int FAST_P = 421;
  localparam int SLOW_P = 447;

  logic       sys_clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks;
  int failures;

  logic [7:0] rx_q[$];
  int         valid_cnt;
  int         err_cnt;
  int         both_cnt;
  int         long_cnt;
  int         busy_cycles;
  logic       prev_valid;
  logic       prev_err;

  uart_rx_byte #(
    .CLK_FREQ(50_000_000),
    .BAUD    (115200)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Observe the DUT on the falling edge, away from the active clock edge.
  initial begin
    valid_cnt   = 0;
    err_cnt     = 0;
    both_cnt    = 0;
    long_cnt    = 0;
    busy_cycles = 0;
    prev_valid  = 1'b0;
    prev_err    = 1'b0;
  end

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        valid_cnt++;
        if (prev_valid) long_cnt++;
      end
      if (rx_frame_err) begin
        err_cnt++;
        if (prev_err) long_cnt++;
      end
      if (rx_valid && rx_frame_err) both_cnt++;
      if (rx_busy) busy_cycles++;
    end
    prev_valid = rx_valid;
    prev_err   = rx_frame_err;
  end

  initial begin
    #1_800_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame. Each bit lasts 'period' clocks. When glitch_bit
  // names a data bit, that bit is inverted for a single clock at offset
  // glitch_at within the bit.
  task automatic applyStimulus(input logic [7:0] data, input int period,
                               input logic stop_val, input int glitch_bit,
                               input int glitch_at);
    logic [9:0] frame;
    frame = {stop_val, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < period; c++) begin
        if ((glitch_bit >= 0) && (b == glitch_bit + 1) && (c == glitch_at))
          uart_rx = ~frame[b];
        else
          uart_rx = frame[b];
        wait_cycles(1);
      end
    end
    uart_rx = 1'b1;
  endtask

  int v0, e0;
  logic [7:0] got;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    wait_cycles(5);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    checkOutput("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(20);

    // Test 1: back-to-back 0x55 then 0xA3
    v0 = valid_cnt; e0 = err_cnt;
    applyStimulus(8'h55, BIT_P, 1'b1, -1, 0);
    applyStimulus(8'hA3, BIT_P, 1'b1, -1, 0);
    wait_cycles(50);
    checkOutput("b2b_valid_count", valid_cnt - v0, 2);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("b2b_byte0", {24'd0, got}, 32'h55);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("b2b_byte1", {24'd0, got}, 32'hA3);
    checkOutput("b2b_frame_err", err_cnt - e0, 0);

    // Test 2: 100-clock low glitch on idle line is a false start
    v0 = valid_cnt; e0 = err_cnt; busy_cycles = 0;
    uart_rx = 1'b0;
    wait_cycles(100);
    uart_rx = 1'b1;
    wait_cycles(BIT_P);
    checkOutput("glitch_no_valid", valid_cnt - v0, 0);
    checkOutput("glitch_no_err", err_cnt - e0, 0);
    checkOutput("glitch_busy_len_ok",
                {31'd0, (busy_cycles >= HALF) && (busy_cycles <= HALF + 3)}, 1);
    checkOutput("glitch_rx_data_held", {24'd0, rx_data}, 32'hA3);
    checkOutput("glitch_back_idle", {31'd0, rx_busy}, 0);

    // Test 3: 0x0F with low stop bit, then 0x3C normally
    v0 = valid_cnt; e0 = err_cnt;
    applyStimulus(8'h0F, BIT_P, 1'b0, -1, 0);
    wait_cycles(BIT_P);
    checkOutput("ferr_pulse_count", err_cnt - e0, 1);
    checkOutput("ferr_no_valid", valid_cnt - v0, 0);
    checkOutput("ferr_rx_data_held", {24'd0, rx_data}, 32'hA3);
    v0 = valid_cnt;
    applyStimulus(8'h3C, BIT_P, 1'b1, -1, 0);
    wait_cycles(50);
    checkOutput("after_ferr_valid_count", valid_cnt - v0, 1);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("after_ferr_byte", {24'd0, got}, 32'h3C);

    // Test 4: 0xC3 with 1-clock inverted glitch at mid-point of bit 2
    v0 = valid_cnt;
    applyStimulus(8'hC3, BIT_P, 1'b1, 2, HALF);
    wait_cycles(50);
    checkOutput("vote_valid_count", valid_cnt - v0, 1);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("vote_byte", {24'd0, got}, 32'hC3);

    // Test 5: reset during bit 4 of 0xF0 (bits 4..7 and stop are high, so the
    // rest of the aborted frame cannot produce a new start edge)
    v0 = valid_cnt; e0 = err_cnt;
    fork
      applyStimulus(8'hF0, BIT_P, 1'b1, -1, 0);
      begin
        wait_cycles(5 * BIT_P + 200);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("midreset_rx_busy", {31'd0, rx_busy}, 0);
        checkOutput("midreset_rx_valid", {31'd0, rx_valid}, 0);
        wait_cycles(5);
        rst_n = 1'b1;
      end
    join
    wait_cycles(50);
    checkOutput("aborted_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 0);
    applyStimulus(8'h81, BIT_P, 1'b1, -1, 0);
    wait_cycles(50);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("post_reset_byte", {24'd0, got}, 32'h81);

    // Test 6: transmitter 3% fast and 3% slow
    e0 = err_cnt;
    applyStimulus(8'h00, FAST_P, 1'b1, -1, 0);
    wait_cycles(50);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("fast_00", {24'd0, got}, 32'h00);
    applyStimulus(8'hFF, FAST_P, 1'b1, -1, 0);
    wait_cycles(50);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("fast_FF", {24'd0, got}, 32'hFF);
    applyStimulus(8'h00, SLOW_P, 1'b1, -1, 0);
    wait_cycles(50);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("slow_00", {24'd0, got}, 32'h00);
    applyStimulus(8'hFF, SLOW_P, 1'b1, -1, 0);
    wait_cycles(50);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    checkOutput("slow_FF", {24'd0, got}, 32'hFF);
    checkOutput("rate_no_frame_err", err_cnt - e0, 0);

    // Whole-run pulse properties
    checkOutput("valid_err_never_both", both_cnt, 0);
    checkOutput("pulses_single_cycle", long_cnt, 0);
    checkOutput("no_extra_bytes", rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
